// File: rtl/score_display_ctrl_pkg.sv
// Shared types and constants for the score display controller: FSM states,
// widths, the seven-segment table and the double-dabble iteration step.
package score_display_ctrl_pkg;

    localparam int SCORE_W = 10;
    localparam int DIGITS  = 4;
    localparam int BCD_W   = 4 * DIGITS;
    localparam int DD_W    = BCD_W + SCORE_W;

    // Active-low {g,f,e,d,c,b,a}; entry 9 first so SEG_TABLE[n] is digit n.
    localparam logic [6:0] SEG_BLANK = 7'h7F;
    localparam logic [9:0][6:0] SEG_TABLE = {
        7'h10, 7'h00, 7'h78, 7'h02, 7'h12,
        7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CONVERT,
        ST_DONE
    } state_t;

    // One double-dabble iteration: correct every BCD nibble >= 5, then shift.
    function automatic logic [DD_W-1:0] dabble_step(input logic [DD_W-1:0] r);
        logic [DD_W-1:0] t;
        t = r;
        for (int k = 0; k < DIGITS; k++) begin
            if (t[SCORE_W + 4*k +: 4] >= 4'd5)
                t[SCORE_W + 4*k +: 4] = t[SCORE_W + 4*k +: 4] + 4'd3;
        end
        return {t[DD_W-2:0], 1'b0};
    endfunction

endpackage

// File: rtl/score_display_ctrl_seg7_decode.sv
// Combinational BCD nibble to active-low seven-segment decoder with blanking.
module seg7_decode
    import score_display_ctrl_pkg::*;
(
    input  logic [3:0] i_nib,
    input  logic       i_blank,
    output logic [6:0] o_seg
);

    always_comb begin
        o_seg = SEG_BLANK;
        if (!i_blank && (i_nib <= 4'd9))
            o_seg = SEG_TABLE[i_nib];
    end

endmodule

// File: rtl/score_display_ctrl.sv
// Samples the CPU score, converts it to BCD with a sequential double-dabble,
// tracks the session high score and scans a 4-digit active-low display.
module score_display_ctrl
    import score_display_ctrl_pkg::*;
#(
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [SCORE_W-1:0] score,
    input  logic               show_high,
    output logic [BCD_W-1:0]   bcd,
    output logic [SCORE_W-1:0] high_score,
    output logic               busy,
    output logic [6:0]         seg,
    output logic [3:0]         an
);

    localparam int CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

    state_t             r_state, w_state_nxt;
    logic [DD_W-1:0]    r_sr, w_sr_nxt;
    logic [3:0]         r_iter, w_iter_nxt;
    logic [SCORE_W-1:0] r_cap, w_cap_nxt;
    logic [SCORE_W-1:0] r_last, w_last_nxt;
    logic               r_pend, w_pend_nxt;
    logic               r_busy, w_busy_nxt;
    logic [BCD_W-1:0]   r_bcd, w_bcd_nxt;
    logic [SCORE_W-1:0] r_high, w_high_nxt;
    logic [BCD_W-1:0]   r_hbcd, w_hbcd_nxt;
    logic               w_change;
    logic               w_start;

    assign w_change = (score != r_last);

    always_comb begin
        w_state_nxt = r_state;
        w_sr_nxt    = r_sr;
        w_iter_nxt  = r_iter;
        w_cap_nxt   = r_cap;
        w_last_nxt  = r_last;
        w_pend_nxt  = r_pend;
        w_busy_nxt  = r_busy;
        w_bcd_nxt   = r_bcd;
        w_high_nxt  = r_high;
        w_hbcd_nxt  = r_hbcd;
        w_start     = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_change || r_pend)
                    w_start = 1'b1;
            end
            ST_CONVERT: begin
                // Remember only the newest value; the running conversion finishes.
                if (w_change) begin
                    w_pend_nxt = 1'b1;
                    w_last_nxt = score;
                end
                w_sr_nxt   = dabble_step(r_sr);
                w_iter_nxt = r_iter + 4'd1;
                if (r_iter == 4'd9)
                    w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_bcd_nxt  = r_sr[DD_W-1:SCORE_W];
                w_busy_nxt = 1'b0;
                if (r_cap > r_high) begin
                    w_high_nxt = r_cap;
                    w_hbcd_nxt = r_sr[DD_W-1:SCORE_W];
                end
                // A change arriving in this very cycle also counts as pending.
                if (r_pend || w_change)
                    w_start = 1'b1;
                else
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (w_start) begin
            w_cap_nxt   = score;
            w_last_nxt  = score;
            w_sr_nxt    = {{BCD_W{1'b0}}, score};
            w_iter_nxt  = 4'd0;
            w_busy_nxt  = 1'b1;
            w_pend_nxt  = 1'b0;
            w_state_nxt = ST_CONVERT;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
            r_sr    <= '0;
            r_iter  <= '0;
            r_cap   <= '0;
            r_last  <= '0;
            r_pend  <= 1'b0;
            r_busy  <= 1'b0;
            r_bcd   <= '0;
            r_high  <= '0;
            r_hbcd  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_sr    <= w_sr_nxt;
            r_iter  <= w_iter_nxt;
            r_cap   <= w_cap_nxt;
            r_last  <= w_last_nxt;
            r_pend  <= w_pend_nxt;
            r_busy  <= w_busy_nxt;
            r_bcd   <= w_bcd_nxt;
            r_high  <= w_high_nxt;
            r_hbcd  <= w_hbcd_nxt;
        end
    end

    assign bcd        = r_bcd;
    assign high_score = r_high;
    assign busy       = r_busy;

    logic [CNT_W-1:0]  r_cnt;
    logic [1:0]        r_sel;
    logic [6:0]        r_seg;
    logic [3:0]        r_an;
    logic [BCD_W-1:0]  w_src;
    logic [DIGITS-1:0] w_blank;
    logic              w_run;
    logic [3:0]        w_nib;
    logic [6:0]        w_seg;

    assign w_src = show_high ? r_hbcd : r_bcd;
    assign w_nib = w_src[{r_sel, 2'b00} +: 4];

    // Digit k>0 goes dark when it and every higher digit are zero.
    always_comb begin
        w_blank = '0;
        w_run   = (BLANK_LZ != 0);
        for (int k = DIGITS-1; k > 0; k--) begin
            w_run      = w_run && (w_src[4*k +: 4] == 4'd0);
            w_blank[k] = w_run;
        end
    end

    seg7_decode u_seg7 (
        .i_nib   (w_nib),
        .i_blank (w_blank[r_sel]),
        .o_seg   (w_seg)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_sel <= 2'd0;
            r_seg <= SEG_BLANK;
            r_an  <= 4'hF;
        end else begin
            if (r_cnt == CNT_W'(SCAN_DIV - 1)) begin
                r_cnt <= '0;
                r_sel <= r_sel + 2'd1;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_seg <= w_seg;
            r_an  <= ~(4'b0001 << r_sel);
        end
    end

    assign seg = r_seg;
    assign an  = r_an;

endmodule

// File: tb/tb_score_display_ctrl.sv
// Directed self-checking bench for score_display_ctrl with a short scan period.
module tb_score_display_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [9:0]  score = 10'd0;
    logic        show_high = 1'b0;
    logic [15:0] bcd;
    logic [9:0]  high_score;
    logic        busy;
    logic [6:0]  seg;
    logic [3:0]  an;

    int errors = 0;
    int checks = 0;

    score_display_ctrl #(.SCAN_DIV(4), .BLANK_LZ(1)) dut (
        .clk        (clk),
        .reset      (reset),
        .score      (score),
        .show_high  (show_high),
        .bcd        (bcd),
        .high_score (high_score),
        .busy       (busy),
        .seg        (seg),
        .an         (an)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Watch one full scan and check the segments shown on each enabled digit.
    task automatic scan_chk(input string tag, input logic [6:0] e0, input logic [6:0] e1,
                            input logic [6:0] e2, input logic [6:0] e3);
        logic [3:0] seen;
        seen = 4'h0;
        for (int i = 0; i < 16; i++) begin
            tick();
            case (an)
                4'hE: begin chk(tag, seg, e0); seen[0] = 1'b1; end
                4'hD: begin chk(tag, seg, e1); seen[1] = 1'b1; end
                4'hB: begin chk(tag, seg, e2); seen[2] = 1'b1; end
                4'h7: begin chk(tag, seg, e3); seen[3] = 1'b1; end
                default: chk({tag, "_an"}, an, 4'hE);
            endcase
        end
        chk({tag, "_seen"}, seen, 4'hF);
    endtask

    initial begin
        logic [3:0] exp_an;
        logic       saw_busy;

        // Reset state
        repeat (3) tick();
        chk("rst_bcd", bcd, 16'h0000);
        chk("rst_high", high_score, 10'd0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_an", an, 4'hF);
        chk("rst_seg", seg, 7'h7F);

        // Release; scan E,D,B,7 with 4 cycles each, only ones digit lit with "0"
        reset = 1'b1;
        for (int k = 1; k <= 17; k++) begin
            tick();
            case (((k - 1) / 4) % 4)
                0: exp_an = 4'hE;
                1: exp_an = 4'hD;
                2: exp_an = 4'hB;
                default: exp_an = 4'h7;
            endcase
            chk("scan_an", an, exp_an);
            chk("scan_seg", seg, (exp_an == 4'hE) ? 7'h40 : 7'h7F);
            chk("idle_busy", busy, 1'b0);
        end

        // 0 -> 1023: busy for 11 cycles, result on the 12th
        score = 10'd1023;
        for (int i = 1; i <= 11; i++) begin
            tick();
            chk("cv1023_busy", busy, 1'b1);
        end
        chk("cv1023_bcd_early", bcd, 16'h0000);
        tick();
        chk("cv1023_busy_done", busy, 1'b0);
        chk("cv1023_bcd", bcd, 16'h1023);
        chk("cv1023_high", high_score, 10'd1023);
        tick();
        scan_chk("disp1023", 7'h30, 7'h24, 7'h40, 7'h79);

        // Asynchronous reset mid-cycle, back to score 0
        #2 reset = 1'b0;
        score = 10'd0;
        #1;
        chk("rst2_high", high_score, 10'd0);
        tick();
        reset = 1'b1;
        tick();

        // 0 -> 57, then 300 four cycles later: two conversions, not three
        score = 10'd57;
        repeat (4) tick();
        score = 10'd300;
        repeat (8) tick();
        chk("p57_bcd", bcd, 16'h0057);
        chk("p57_high", high_score, 10'd57);
        chk("p57_busy_restart", busy, 1'b1);
        repeat (10) tick();
        chk("p300_busy_late", busy, 1'b1);
        chk("p300_bcd_early", bcd, 16'h0057);
        tick();
        chk("p300_bcd", bcd, 16'h0300);
        chk("p300_high", high_score, 10'd300);
        chk("p300_busy", busy, 1'b0);
        saw_busy = 1'b0;
        repeat (20) begin
            tick();
            if (busy) saw_busy = 1'b1;
        end
        chk("no_third_conv", saw_busy, 1'b0);

        // 500 then 120; high score display keeps 500
        score = 10'd500;
        repeat (12) tick();
        chk("s500_bcd", bcd, 16'h0500);
        chk("s500_high", high_score, 10'd500);
        score = 10'd120;
        repeat (12) tick();
        chk("s120_bcd", bcd, 16'h0120);
        chk("s120_high", high_score, 10'd500);
        show_high = 1'b1;
        tick();
        scan_chk("disp_high500", 7'h40, 7'h40, 7'h12, 7'h7F);
        show_high = 1'b0;
        tick();
        scan_chk("disp_120", 7'h40, 7'h24, 7'h79, 7'h7F);

        // Reset in the middle of a conversion (iter = 5)
        score = 10'd777;
        repeat (6) tick();
        chk("mid_busy", busy, 1'b1);
        #2 reset = 1'b0;
        #1;
        chk("mid_rst_bcd", bcd, 16'h0000);
        chk("mid_rst_high", high_score, 10'd0);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_an", an, 4'hF);
        chk("mid_rst_seg", seg, 7'h7F);
        tick();
        reset = 1'b1;
        repeat (11) tick();
        chk("re777_busy", busy, 1'b1);
        tick();
        chk("re777_busy_done", busy, 1'b0);
        chk("re777_bcd", bcd, 16'h0777);
        chk("re777_high", high_score, 10'd777);

        // Unchanged score starts nothing
        saw_busy = 1'b0;
        repeat (5) begin
            tick();
            if (busy) saw_busy = 1'b1;
        end
        chk("equal_no_busy", saw_busy, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/score_display_ctrl.md
Name: score_display_ctrl

Overview:
Downstream consumer of the score-computing CPU stage. It samples the 10-bit score and converts it to four BCD digits with a sequential double-dabble engine. It tracks the session high score and time-multiplexes a 4-digit active-low seven-segment display.

Parameters:
SCAN_DIV, 50000, clock cycles each digit is lit before the scan advances (minimum 2).
BLANK_LZ, 1, 1 = blank leading zeros on the display; digit 0 is never blanked.

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  asynchronous, active-low reset.
score  input  10  current score from the CPU stage; sampled every cycle.
show_high  input  1  1 = display high score, 0 = display current score.
bcd  output  16  BCD of the last converted score; [3:0] = ones, [15:12] = thousands.
high_score  output  10  largest score captured since reset.
busy  output  1  high while a conversion is in progress.
seg  output  7  segments {g,f,e,d,c,b,a}; active-low.
an  output  4  digit enables; active-low; an[0] = ones.

Behaviour:
- Reset (reset = 0, asynchronous):
  - bcd = 0, high_score = 0, busy = 0, FSM = IDLE, pending = 0.
  - score_last = 0, scan counter = 0, digit select = 0.
  - seg = 7'h7F, an = 4'hF (all dark).
  - First cycle after release: an = 4'hE showing "0", because high_score = 0 and bcd = 0.
- Change detect: change = (score != score_last), evaluated every clock.
- FSM states: IDLE, CONVERT, DONE.
- IDLE:
  - On change, capture cap = score and set score_last = score.
  - Load the shift register with {16'b0, cap}, set iter = 0, busy = 1, go to CONVERT.
- CONVERT, one iteration per cycle, 10 iterations:
  - Each BCD nibble >= 5 gets +3.
  - Then shift the 26-bit register left by 1 and increment iter.
  - After iter reaches 10, go to DONE.
- DONE, one cycle:
  - bcd <= upper 16 bits of the register.
  - If cap > high_score, high_score <= cap.
  - busy <= 0.
  - If pending = 1, clear pending and start a new capture (as in IDLE) in the same cycle; otherwise go to IDLE.
- Latency: score changes at cycle N (sampled at edge N). busy = 1 from N+1. bcd and high_score are valid at N+12.
- Score change while busy:
  - Set pending = 1 and track only the newest value in score_last.
  - Conversions are never aborted. Intermediate values may be skipped; the final value is always converted.
- Equal score: no conversion starts and busy stays 0.
- Arithmetic:
  - 10-bit unsigned score, range 0..1023, so the thousands digit is 0 or 1.
  - high_score comparison is unsigned.
- Display source:
  - show_high = 0: shows bcd.
  - show_high = 1: shows a BCD image of high_score, updated in DONE alongside high_score (second 16-bit register, high_bcd).
  - Switching source takes effect on the next digit refresh; no glitch exceeds one cycle.
- Scan:
  - The counter counts 0..SCAN_DIV-1, then wraps and increments a 2-bit digit select (3 wraps to 0).
  - an = ~(4'b0001 << sel).
  - seg is decoded from the selected nibble: 0-9 standard; 10-15 give all dark (unreachable).
- Leading-zero blank (BLANK_LZ = 1): digit k > 0 is dark when it and all higher digits are 0.
- bcd, seg and an are registered outputs.

Decomposition:
- Shared package holds:
  - FSM state typedef (IDLE, CONVERT, DONE).
  - SCORE_W = 10, DIGITS = 4.
  - Seven-segment constant table for 0-9 plus SEG_BLANK = 7'h7F.
- One natural sub-module, seg7_decode: a combinational nibble-to-segment decoder with a blank input.
- Double-dabble engine and scan logic stay in the top module.

Test Plan:
- Reset released with score = 0 -> bcd = 16'h0000, busy = 0, an = 4'hE, seg = 7'h40 ("0"); an[3:1] never low.
- score steps 0 -> 1023 at cycle N -> busy = 1 at N+1..N+11; bcd = 16'h1023 and high_score = 1023 at N+12; all four digits scan.
- score 0 -> 57 -> 300, the second change at N+4 -> the first conversion completes to 16'h0057, then exactly one more yields 16'h0300; no third conversion; high_score = 300.
- score 500 then 120, show_high = 1 -> display reads "500" with digit 3 blank; high_score stays 500; bcd = 16'h0120.
- reset asserted mid-CONVERT at iter = 5 -> all outputs immediately return to reset values; after release with unchanged nonzero score, a new conversion starts and completes in 12 cycles.
- SCAN_DIV = 4 -> an cycles E, D, B, 7 every 4 cycles, wrapping after 16.
